axi_gp_master: RTL

- PL-side AXI3 initiator that issues single-beat 32-bit reads/writes into a Zynq PS7 slave port (S_AXI_GP/HP).
- This is the reverse direction of the existing PS7-master to PL-slave register path.
- Local logic (DMA sequencer, self-test, IRQ mailbox) hands it one command at a time and gets back one response.
- Each transaction runs to completion or to a timeout.

---
 rtl/axi_pkg.sv | 10 +
 rtl/axi_timeout_ctr.sv | 19 +
 rtl/axi_gp_master.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI3 response/burst/size constants and the initiator FSM state type.
package axi_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    typedef enum logic [2:0] {ST_IDLE, ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA, ST_RESP} state_t;
endpackage

// File: rtl/axi_timeout_ctr.sv
// axi_timeout_ctr: saturating idle-cycle counter; expired flags the last allowed cycle.
module axi_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
    end
    assign expired = (TIMEOUT != 0) && enable && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/axi_gp_master.sv
// axi_gp_master: single-beat AXI3 initiator into a PS7 slave port, one transaction at a time,
// each ending in a response or a timeout abort.
module axi_gp_master #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 6,
    parameter int ID      = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [3:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic [ID_W-1:0]   m_axi_wid,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [3:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    import axi_pkg::*;
    state_t state;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, hs, busy, expired;
    logic unused;
    assign m_axi_awid    = ID_W'(ID);
    assign m_axi_wid     = ID_W'(ID);
    assign m_axi_arid    = ID_W'(ID);
    assign m_axi_awlen   = 4'd0;
    assign m_axi_arlen   = 4'd0;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_wlast   = 1'b1;
    // IDs, rlast and the address byte lane are deliberately not checked or used
    assign unused = ^{m_axi_bid, m_axi_rid, m_axi_rlast, cmd_addr[1:0]};
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign b_hs  = m_axi_bready && m_axi_bvalid;
    assign r_hs  = m_axi_rready && m_axi_rvalid;
    assign hs    = aw_hs || w_hs || ar_hs || b_hs || r_hs;
    assign busy  = state == ST_WADDR || state == ST_WRESP || state == ST_RADDR || state == ST_RDATA;
    axi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (!busy || hs),
        .enable  (busy),
        .expired (expired)
    );
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            rsp_timeout   <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    cmd_ready    <= 1'b0;
                    m_axi_awaddr <= {cmd_addr[ADDR_W-1:2], 2'b00};
                    m_axi_araddr <= {cmd_addr[ADDR_W-1:2], 2'b00};
                    m_axi_wdata  <= cmd_wdata;
                    m_axi_wstrb  <= cmd_wstrb;
                    if (cmd_write) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= ST_WADDR;
                    end else begin
                        m_axi_arvalid <= 1'b1;
                        state         <= ST_RADDR;
                    end
                end
                ST_WADDR: begin
                    if (aw_hs) m_axi_awvalid <= 1'b0;
                    if (w_hs) m_axi_wvalid <= 1'b0;
                    if ((!m_axi_awvalid || aw_hs) && (!m_axi_wvalid || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WRESP;
                    end
                end
                ST_WRESP: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    rsp_resp     <= m_axi_bresp;
                    rsp_rdata    <= '0;
                    rsp_timeout  <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RADDR: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= ST_RDATA;
                end
                ST_RDATA: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    rsp_resp     <= m_axi_rresp;
                    rsp_rdata    <= m_axi_rdata;
                    rsp_timeout  <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // a handshake in the expiring cycle means progress, so abort only when none happened
            if (expired && !hs) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_rready  <= 1'b0;
                rsp_resp      <= AXI_RESP_SLVERR;
                rsp_rdata     <= '0;
                rsp_timeout   <= 1'b1;
                rsp_valid     <= 1'b1;
                state         <= ST_RESP;
            end
        end
    end
endmodule
